mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-transfer initiator that drives the 24-bit single-port data memory (address, write-data, read-data, write-enable, read-enable) to copy or fill a contiguous region of words without processor involvement. It sits beside the datapath as a second master on the memory port. Arbitration is external: the core must not touch memory while `busy` is high. One transfer is programmed per `start` pulse, and completion is signalled with a one-cycle `done` pulse.

## Interface
- `AW`, 24, address width in bits (word addressed)
- `DW`, 24, data word width in bits
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  launch request; sampled only in IDLE
- `fill`  in  1  mode, sampled with `start`: 0 = copy src→dst, 1 = write `pattern` to dst
- `src_addr`  in  AW  first source word (ignored when fill=1)
- `dst_addr`  in  AW  first destination word
- `length`  in  AW  word count; 0 is legal
- `pattern`  in  DW  fill value, sampled with `start`
- `busy`  out  1  high in READ, WRITE and FILL
- `done`  out  1  one-cycle completion pulse
- `words_done`  out  AW  words written in the current or last transfer
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data; combinational from `mem_addr` while `mem_r`=1, otherwise 0
- `mem_w`  out  1  write enable; memory writes at posedge
- `mem_r`  out  1  read enable

## Operation
- States: IDLE, READ, WRITE, FILL, DONE. Moore outputs are decoded from the registered state only.
- IDLE: on `start`=1, latch `src_addr`, `dst_addr`, `length`, `pattern` and `fill`, and clear `words_done`.
  - length=0 → DONE.
  - fill=1 → FILL.
  - Otherwise → READ.
- READ: `mem_r`=1, `mem_addr`=src pointer. At the posedge, capture `mem_rdata` into the data register and go to WRITE.
- WRITE: `mem_w`=1, `mem_addr`=dst pointer, `mem_wdata`=data register. At the posedge:
  - increment src and dst pointers;
  - decrement the remaining count;
  - increment `words_done`;
  - if the remaining count was 1 → DONE, else → READ.
- FILL: `mem_w`=1, `mem_addr`=dst pointer, `mem_wdata`=latched pattern. At the posedge:
  - increment the dst pointer, decrement the remaining count, increment `words_done`;
  - if the remaining count was 1 → DONE, else stay in FILL.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- Pointers wrap modulo 2^AW: 0xFFFFFF+1 = 0x000000. No error is raised.
- Copy is always ascending. With overlapping regions where dst>src, already-written words are re-read; the resulting propagation is the defined behaviour.
- `start` outside IDLE is ignored, including in DONE. The input latches do not change during a transfer.
- In IDLE and DONE: `mem_w`=`mem_r`=0, `mem_addr`=0, `mem_wdata`=0.
- `mem_r` and `mem_w` are never both 1.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE;
  - `busy`=`done`=`mem_w`=`mem_r`=0;
  - `mem_addr`=`mem_wdata`=0, `words_done`=0;
  - internal pointers, count and data register = 0.
- Reset mid-transfer aborts at once. A write in progress is dropped because `mem_w` falls before the next edge. No resume.
- Start accepted at edge E0:
  - Copy of N≥1 words: first READ cycle follows E0; `done` is high in cycle 2N+1 after E0.
  - Fill: `done` is high in cycle N+1.
  - length=0: `done` is high in cycle 1, with no memory access.
- `busy` falls in the same cycle `done` rises. A new `start` is accepted no earlier than the IDLE cycle after `done`.
- `words_done` holds its final value until the next accepted `start`.

## Test plan
- Copy: mem[0x10..0x13]=A,B,C,D; start src=0x10, dst=0x40, len=4 → mem[0x40..0x43]=A,B,C,D; `done` exactly 9 cycles after start; `words_done`=4; 4 reads and 4 writes, alternating.
- Fill: start fill=1, dst=0x100, len=3, pattern=0xABCDEF → mem[0x100..0x102]=0xABCDEF; `done` 4 cycles after start; `mem_r` never asserted.
- Zero length: len=0 → `done` in cycle 1; `mem_w`/`mem_r` stay 0; `words_done`=0.
- Wrap: dst=0xFFFFFE, fill, len=3, pattern=7 → mem[0xFFFFFE], mem[0xFFFFFF], mem[0x000000] all =7.
- Overlap plus ignored start: mem[0..1]=5,9; copy src=0, dst=1, len=2 → mem[1]=5, mem[2]=5. A second `start` pulsed mid-transfer has no effect.
- Reset mid-copy: assert `rst` during the 3rd WRITE cycle of a len=8 copy → outputs go to 0 immediately; only 2 destination words are modified; after release the engine is IDLE and the next start works normally.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Memory-port bundle between the copy engine (master) and the
// single-port data memory (slave).
interface mem_copy_engine_if #(
  parameter int AW = 24,
  parameter int DW = 24
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_w;
  logic          mem_r;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_w,
    output mem_r,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_w,
    input  mem_r,
    output mem_rdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy/fill initiator acting as a second master on the data memory.
// One transfer per start pulse; busy while moving words, one-cycle done.
module mem_copy_engine #(
  parameter int AW = 24,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fill,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] words_done,
  mem_copy_engine_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, READ, WRITE, FILL, DONE
  } state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] words_q, words_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] pat_q, pat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_w_q, mem_w_d;
  logic          mem_r_q, mem_r_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    data_d  = data_q;
    pat_d   = pat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = length;
          pat_d   = pattern;
          words_d = '0;
          if (length == '0) state_d = DONE;
          else if (fill)    state_d = FILL;
          else              state_d = READ;
        end
      end
      READ: begin
        data_d  = bus.mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + ONE;
        dst_d   = dst_q + ONE;
        cnt_d   = cnt_q - ONE;
        words_d = words_q + ONE;
        state_d = (cnt_q == ONE) ? DONE : READ;
      end
      FILL: begin
        dst_d   = dst_q + ONE;
        cnt_d   = cnt_q - ONE;
        words_d = words_q + ONE;
        state_d = (cnt_q == ONE) ? DONE : FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mem_w_d = 1'b0;
    mem_r_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      READ: begin
        busy_d  = 1'b1;
        mem_r_d = 1'b1;
        addr_d  = src_d;
      end
      WRITE: begin
        busy_d  = 1'b1;
        mem_w_d = 1'b1;
        addr_d  = dst_d;
        wdata_d = data_d;
      end
      FILL: begin
        busy_d  = 1'b1;
        mem_w_d = 1'b1;
        addr_d  = dst_d;
        wdata_d = pat_d;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mem_w_q <= 1'b0;
      mem_r_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mem_w_q <= mem_w_d;
      mem_r_q <= mem_r_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign words_done    = words_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_r     = mem_r_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a word-level reference model
// queues expected reads, writes and done pulses; a monitor checks them.
module tb_mem_copy_engine;
  typedef struct {
    logic [23:0] wa;
    logic [23:0] wd;
  } wr_t;

  typedef struct {
    int          c;
    logic [23:0] w;
  } dn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [23:0] src_addr = '0;
  logic [23:0] dst_addr = '0;
  logic [23:0] length = '0;
  logic [23:0] pattern = '0;
  logic        busy;
  logic        done;
  logic [23:0] words_done;

  mem_copy_engine_if #(.AW(24), .DW(24)) bus ();

  mem_copy_engine #(.AW(24), .DW(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fill       (fill),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .pattern    (pattern),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .bus        (bus)
  );

  initial forever #5 clk = ~clk;

  // 4K-word memory, aliased on the low 12 address bits (model does the same)
  logic [23:0] mem   [4096];
  logic [23:0] ref_m [4096];
  bit          touched [4096];
  logic        tb_we = 1'b0;
  logic [11:0] tb_wa = '0;
  logic [23:0] tb_wd = '0;

  always @(posedge clk) begin
    if (bus.mem_w) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  assign bus.mem_rdata = bus.mem_r ? mem[bus.mem_addr[11:0]] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] rdq [$];
  wr_t         wrq [$];
  dn_t         dnq [$];
  logic [23:0] last_n = '0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] rf(input logic [23:0] a);
    return ref_m[a[11:0]];
  endfunction

  task automatic wr_mem(input logic [23:0] a, input logic [23:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a[11:0];
    tb_wd = v;
    ref_m[a[11:0]] = v;
    touched[a[11:0]] = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Reference: word i of a transfer writes dst+i with pattern or the
  // current content of src+i, in ascending order, addresses mod 2^24.
  task automatic run(input bit f, input logic [23:0] s,
                     input logic [23:0] d, input int n,
                     input logic [23:0] p, input bit junk);
    int          lat;
    bit          seen;
    logic [23:0] a;
    logic [23:0] v;
    @(negedge clk);
    chk("words_hold", words_done, last_n);
    start = 1'b1;
    fill = f;
    src_addr = s;
    dst_addr = d;
    length = 24'(n);
    pattern = p;
    for (int i = 0; i < n; i++) begin
      a = d + 24'(i);
      if (f) v = p;
      else begin
        v = rf(s + 24'(i));
        rdq.push_back(s + 24'(i));
      end
      ref_m[a[11:0]] = v;
      touched[a[11:0]] = 1'b1;
      wrq.push_back('{wa: a, wd: v});
    end
    lat = (n == 0) ? 1 : (f ? n + 1 : 2 * n + 1);
    dnq.push_back('{c: cyc + lat, w: 24'(n)});
    last_n = 24'(n);
    seen = 1'b0;
    for (int k = 0; k < lat + 4 && !seen; k++) begin
      @(negedge clk);
      seen = done;
      start = junk ? ~start : 1'b0;
      if (junk) begin
        fill = 1'($urandom);
        src_addr = 24'($urandom);
        dst_addr = 24'($urandom);
        length = 24'($urandom_range(1, 5));
        pattern = 24'($urandom);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every access and done pulse must match the queued expectation
  initial forever begin
    wr_t         e;
    dn_t         dn;
    logic [23:0] ra;
    @(negedge clk);
    if (!rst) begin
      chk("rw_exclusive", bus.mem_w & bus.mem_r, 0);
      chk("busy", busy, bus.mem_r | bus.mem_w);
      if (!busy)
        chk("idle_bus", {bus.mem_addr, bus.mem_wdata}, 0);
      if (bus.mem_r) begin
        if (rdq.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          ra = rdq.pop_front();
          chk("rd_addr", bus.mem_addr, ra);
        end
      end
      if (bus.mem_w) begin
        if (wrq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wrq.pop_front();
          chk("wr_addr", bus.mem_addr, e.wa);
          chk("wr_data", bus.mem_wdata, e.wd);
        end
      end
      if (done) begin
        if (dnq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          dn = dnq.pop_front();
          chk("done_cycle", cyc, dn.c);
          chk("done_words", words_done, dn.w);
        end
      end
    end
  end

  function automatic logic [23:0] rand_addr();
    if ($urandom_range(3) == 0)
      return 24'hFFFFFF - 24'($urandom_range(3));
    return 24'($urandom);
  endfunction

  initial begin
    logic [23:0] s;
    logic [23:0] d;
    int          n;
    bit          f;
    int          diffs;

    #1 rst = 1'b1;
    #2;
    chk("rst_outputs", {busy, done, bus.mem_w, bus.mem_r,
        bus.mem_addr, bus.mem_wdata, words_done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wr_mem(24'h10, 24'h111111);
    wr_mem(24'h11, 24'h222222);
    wr_mem(24'h12, 24'h333333);
    wr_mem(24'h13, 24'h444444);
    run(1'b0, 24'h10, 24'h40, 4, 24'h0, 1'b0);
    chk("copy_m40", mem[12'h040], 24'h111111);
    chk("copy_m41", mem[12'h041], 24'h222222);
    chk("copy_m42", mem[12'h042], 24'h333333);
    chk("copy_m43", mem[12'h043], 24'h444444);

    run(1'b1, 24'h0, 24'h100, 3, 24'hABCDEF, 1'b0);
    chk("fill_m100", mem[12'h100], 24'hABCDEF);
    chk("fill_m102", mem[12'h102], 24'hABCDEF);

    run(1'b0, 24'h500, 24'h600, 0, 24'h0, 1'b0);
    chk("zero_words", words_done, 0);

    run(1'b1, 24'h0, 24'hFFFFFE, 3, 24'h7, 1'b0);
    chk("wrap_fffffe", mem[12'hFFE], 24'h7);
    chk("wrap_ffffff", mem[12'hFFF], 24'h7);
    chk("wrap_000000", mem[12'h000], 24'h7);

    wr_mem(24'h0, 24'h5);
    wr_mem(24'h1, 24'h9);
    run(1'b0, 24'h0, 24'h1, 2, 24'h0, 1'b1);
    chk("ovl_m1", mem[12'h001], 24'h5);
    chk("ovl_m2", mem[12'h002], 24'h5);

    // Reset during the third WRITE of an 8-word copy
    for (int i = 0; i < 8; i++) begin
      wr_mem(24'h200 + 24'(i), 24'($urandom));
      wr_mem(24'h300 + 24'(i), 24'hD00000 + 24'(i));
    end
    @(negedge clk);
    chk("words_hold", words_done, last_n);
    start = 1'b1;
    fill = 1'b0;
    src_addr = 24'h200;
    dst_addr = 24'h300;
    length = 24'd8;
    for (int i = 0; i < 3; i++) rdq.push_back(24'h200 + 24'(i));
    for (int i = 0; i < 2; i++) begin
      ref_m[12'h300 + 12'(i)] = rf(24'h200 + 24'(i));
      wrq.push_back('{wa: 24'h300 + 24'(i),
                      wd: rf(24'h200 + 24'(i))});
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("w3_active", {bus.mem_w, bus.mem_addr}, {1'b1, 24'h302});
    #1 rst = 1'b1;
    #1 chk("abort_outputs", {busy, done, bus.mem_w, bus.mem_r,
        bus.mem_addr, bus.mem_wdata, words_done}, 0);
    chk("abort_reads", rdq.size(), 0);
    chk("abort_writes", wrq.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_n = '0;
    chk("abort_m302", mem[12'h302], 24'hD00002);
    run(1'b0, 24'h200, 24'h310, 3, 24'h0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      f = 1'($urandom);
      n = $urandom_range(6);
      s = rand_addr();
      d = ($urandom_range(2) == 0) ? s + 24'($urandom_range(3))
                                   : rand_addr();
      if (!f)
        for (int i = 0; i < n; i++)
          wr_mem(s + 24'(i), 24'($urandom));
      run(f, s, d, n, 24'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("rdq_empty", rdq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);
    chk("dnq_empty", dnq.size(), 0);
    diffs = 0;
    for (int i = 0; i < 4096; i++)
      if (touched[i] && mem[i] !== ref_m[i]) diffs++;
    chk("mem_final", diffs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
